// File: rtl/gmii2xgmii_pack_if.sv
// GMII byte input and XGMII word output bundle for gmii2xgmii_pack.
// gmii_er exists only when GMII2XGMII_ERR_EN is defined.
interface gmii2xgmii_pack_if;
    logic        gmii_en;
    logic [7:0]  gmii_txd;
`ifdef GMII2XGMII_ERR_EN
    logic        gmii_er;
`endif
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        xgmii_valid;
    logic [15:0] frame_cnt;

`ifdef GMII2XGMII_ERR_EN
    modport master (output gmii_en, gmii_txd, gmii_er,
                    input  xgmii_txd, xgmii_txc, xgmii_valid, frame_cnt);
    modport slave  (input  gmii_en, gmii_txd, gmii_er,
                    output xgmii_txd, xgmii_txc, xgmii_valid, frame_cnt);
`else
    modport master (output gmii_en, gmii_txd,
                    input  xgmii_txd, xgmii_txc, xgmii_valid, frame_cnt);
    modport slave  (input  gmii_en, gmii_txd,
                    output xgmii_txd, xgmii_txc, xgmii_valid, frame_cnt);
`endif
endinterface

// File: rtl/gmii2xgmii_pack.sv
// Packs an 8-bit GMII transmit stream into 64-bit XGMII words with /S/, /T/ and idle insertion.
// Optional feature: define GMII2XGMII_ERR_EN to map gmii_er bytes to /E/.
module gmii2xgmii_pack (
    input  logic              gmii_clk,
    input  logic              sys_rst_n,
    gmii2xgmii_pack_if.slave  bus
);

    localparam logic [63:0] IDLE_TXD  = 64'h0707070707070707;
    localparam logic [7:0]  IDLE_TXC  = 8'hFF;
    localparam logic [63:0] START_TXD = 64'h07070707070707FB;
    localparam logic [7:0]  XG_TERM   = 8'hFD;
`ifdef GMII2XGMII_ERR_EN
    localparam logic [7:0]  XG_ERROR  = 8'hFE;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TERM = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  lane_q, lane_d;
    logic [63:0] asm_txd_q, asm_txd_d;
    logic [7:0]  asm_txc_q, asm_txc_d;
    logic [63:0] xgmii_txd_q, xgmii_txd_d;
    logic [7:0]  xgmii_txc_q, xgmii_txc_d;
    logic        xgmii_valid_q, xgmii_valid_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  byte_s;
    logic        ctl_s;

    function automatic logic [63:0] put_byte(input logic [63:0] word,
                                             input logic [2:0]  lane,
                                             input logic [7:0]  value);
        logic [63:0] res;
        res = word;
        res[{lane, 3'b000} +: 8] = value;
        return res;
    endfunction

    function automatic logic [7:0] put_bit(input logic [7:0] flags,
                                           input logic [2:0] lane,
                                           input logic       value);
        logic [7:0] res;
        res = flags;
        res[lane] = value;
        return res;
    endfunction

    // State register.
    always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.gmii_en) state_d = ST_DATA;
                else             state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (bus.gmii_en) state_d = ST_DATA;
                else             state_d = ST_TERM;
            end
            ST_TERM: begin
                if (bus.gmii_en) state_d = ST_DATA;
                else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte and control flag written into a data lane.
    always_comb begin
`ifdef GMII2XGMII_ERR_EN
        if (bus.gmii_er) begin
            byte_s = XG_ERROR;
            ctl_s  = 1'b1;
        end else begin
            byte_s = bus.gmii_txd;
            ctl_s  = 1'b0;
        end
`else
        byte_s = bus.gmii_txd;
        ctl_s  = 1'b0;
`endif
    end

    // Lane assembly and word emission; the assembly register holds idles in every unwritten lane.
    always_comb begin
        lane_d        = lane_q;
        asm_txd_d     = asm_txd_q;
        asm_txc_d     = asm_txc_q;
        xgmii_txd_d   = xgmii_txd_q;
        xgmii_txc_d   = xgmii_txc_q;
        xgmii_valid_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.gmii_en) begin
                    // Flush any partly filled idle word, then /S/ always lands in lane 0.
                    if (lane_q != 3'd0) begin
                        xgmii_txd_d   = IDLE_TXD;
                        xgmii_txc_d   = IDLE_TXC;
                        xgmii_valid_d = 1'b1;
                    end else begin
                        xgmii_valid_d = 1'b0;
                    end
                    asm_txd_d = START_TXD;
                    asm_txc_d = IDLE_TXC;
                    lane_d    = 3'd1;
                end else begin
                    if (lane_q == 3'd7) begin
                        xgmii_txd_d   = IDLE_TXD;
                        xgmii_txc_d   = IDLE_TXC;
                        xgmii_valid_d = 1'b1;
                    end else begin
                        xgmii_valid_d = 1'b0;
                    end
                    lane_d = lane_q + 3'd1;
                end
            end
            ST_DATA: begin
                if (bus.gmii_en) begin
                    if (lane_q == 3'd7) begin
                        xgmii_txd_d   = put_byte(asm_txd_q, lane_q, byte_s);
                        xgmii_txc_d   = put_bit(asm_txc_q, lane_q, ctl_s);
                        xgmii_valid_d = 1'b1;
                        asm_txd_d     = IDLE_TXD;
                        asm_txc_d     = IDLE_TXC;
                    end else begin
                        asm_txd_d     = put_byte(asm_txd_q, lane_q, byte_s);
                        asm_txc_d     = put_bit(asm_txc_q, lane_q, ctl_s);
                    end
                    lane_d = lane_q + 3'd1;
                end else begin
                    xgmii_txd_d   = put_byte(asm_txd_q, lane_q, XG_TERM);
                    xgmii_txc_d   = put_bit(asm_txc_q, lane_q, 1'b1);
                    xgmii_valid_d = 1'b1;
                    asm_txd_d     = IDLE_TXD;
                    asm_txc_d     = IDLE_TXC;
                    lane_d        = 3'd0;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                end
            end
            ST_TERM: begin
                // The idle lanes after /T/ already padded its word, so this cycle adds no lane.
                if (bus.gmii_en) begin
                    asm_txd_d = START_TXD;
                    asm_txc_d = IDLE_TXC;
                    lane_d    = 3'd1;
                end else begin
                    lane_d    = 3'd0;
                end
            end
            default: begin
                asm_txd_d = IDLE_TXD;
                asm_txc_d = IDLE_TXC;
                lane_d    = 3'd0;
            end
        endcase
    end

    // Datapath registers and registered XGMII outputs.
    always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lane_q        <= 3'd0;
            asm_txd_q     <= IDLE_TXD;
            asm_txc_q     <= IDLE_TXC;
            xgmii_txd_q   <= IDLE_TXD;
            xgmii_txc_q   <= IDLE_TXC;
            xgmii_valid_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            lane_q        <= lane_d;
            asm_txd_q     <= asm_txd_d;
            asm_txc_q     <= asm_txc_d;
            xgmii_txd_q   <= xgmii_txd_d;
            xgmii_txc_q   <= xgmii_txc_d;
            xgmii_valid_q <= xgmii_valid_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign bus.xgmii_txd   = xgmii_txd_q;
    assign bus.xgmii_txc   = xgmii_txc_q;
    assign bus.xgmii_valid = xgmii_valid_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: doc/gmii2xgmii_pack.md
GMII2XGMII_PACK -- requirements
Module: gmii2xgmii_pack

Interface
REQ-001 The block SHALL have these parameters: none; all widths are fixed.
REQ-002 The block SHALL have port gmii_clk, input, 1: the single clock, 125 MHz; every register is clocked on its rising edge.
REQ-003 The block SHALL have port sys_rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port gmii_en, input, 1: GMII transmit enable; high for every frame byte, including the preamble and SFD.
REQ-005 The block SHALL have port gmii_txd, input, 8: the GMII transmit byte.
REQ-006 The block SHALL have port gmii_er, input, 1: GMII transmit error; present only when GMII2XGMII_ERR_EN is defined.
REQ-007 The block SHALL have port xgmii_txd, output, 64: the packed XGMII word; lane 0 is bits [7:0].
REQ-008 The block SHALL have port xgmii_txc, output, 8: the XGMII control flags; bit n qualifies lane n.
REQ-009 The block SHALL have port xgmii_valid, output, 1: a one-cycle strobe marking a new word, intended as the write enable of an external asynchronous FIFO.
REQ-010 The block SHALL have port frame_cnt, output, 16: the count of completed frames; wraps from 0xFFFF to 0.

Function
REQ-011 The block SHALL implement three states: IDLE, DATA and TERM, together with a 3-bit lane counter (lane) and a 64/8-bit assembly register.
REQ-012 In IDLE with gmii_en=0, the block SHALL fill the current lane with 0x07 (txc=1); each cycle it increments lane, and at lane=7 it emits the word and wraps lane to 0.
REQ-013 When gmii_en rises (IDLE and gmii_en=1), the block SHALL enter DATA.
- If lane != 0, it first emits the partial idle word that cycle, with unfilled lanes set to 0x07 and txc=1.
- The start byte is always placed in lane 0 as 0xFB (/S/, txc=1), replacing the first preamble byte; lane becomes 1.
REQ-014 In DATA with gmii_en=1, the block SHALL store gmii_txd in the current lane with txc=0; at lane=7 it emits the word.
REQ-015 On the first cycle in DATA with gmii_en=0, the block SHALL place 0xFD (/T/, txc=1) in the current lane.
- Lanes above it are filled with 0x07 (txc=1).
- The word is emitted that cycle, lane resets to 0, frame_cnt increments and the state goes to TERM.
REQ-016 If gmii_en falls while lane=0, the block SHALL emit a terminate word of 0xFD in lane 0 followed by seven 0x07 lanes, with txc=0xFF.
REQ-017 TERM SHALL last exactly one cycle and then go to IDLE.
- If gmii_en=1 during TERM, the block SHALL treat that cycle as a start, per REQ-013 with lane=0.
REQ-018 "Emit" SHALL mean: xgmii_txd/xgmii_txc are loaded from the assembled word and xgmii_valid=1 on the following clock edge; latency is 1 cycle from the sampling of the last contributing byte.
REQ-019 xgmii_valid SHALL be high for exactly one cycle per emitted word; back-to-back pulses are legal only per REQ-013/REQ-017.
REQ-020 xgmii_txd/xgmii_txc SHALL hold their last value between valid pulses.

Reset
REQ-021 While sys_rst_n=0, the block SHALL hold the following values:
- state=IDLE, lane=0, xgmii_valid=0;
- xgmii_txd=0x0707070707070707, xgmii_txc=0xFF;
- frame_cnt=0; the assembly register is all idle.
REQ-022 If reset is asserted mid-frame, the block SHALL discard the partial frame with no terminate emitted; after release it restarts in IDLE at lane 0.

Configuration
REQ-023 With macro GMII2XGMII_ERR_EN defined, the gmii_er port SHALL exist, and any DATA cycle with gmii_en=1 and gmii_er=1 SHALL store 0xFE (/E/) with txc=1 in place of gmii_txd.
REQ-024 Without GMII2XGMII_ERR_EN, the gmii_er port SHALL be absent and every DATA byte SHALL pass unmodified with txc=0.

Verification
REQ-025 The bench SHALL apply reset, then hold gmii_en=0 for 24 cycles; it SHALL check for 3 valid pulses, 8 cycles apart, each with txd=0x0707070707070707 and txc=0xFF.
REQ-026 The bench SHALL drive a 64-byte frame (55x7, D5, 56 payload bytes 0x00..0x37) starting at lane 0.
- First word: txd=0xD5555555555555FB, txc=0x01.
- Then 7 data words with txc=0x00.
- Then a terminate word of 0x07070707070707FD with txc=0xFF.
- frame_cnt=1.
REQ-027 The bench SHALL start a 61-byte frame at lane 3.
- Check an idle flush word, then /S/ in lane 0 of the next word.
- Check that the terminate word carries 0xFD in lane 5 (txc=0xE0).
REQ-028 The bench SHALL drop gmii_en for one cycle only, between two frames; it SHALL check the terminate pulse immediately followed by a start-word assembly, and frame_cnt stepping by 1 for each frame.
REQ-029 The bench SHALL assert sys_rst_n=0 at byte 20 of a frame; it SHALL check that outputs return to reset values asynchronously and that the next valid pulse is an idle word 8 cycles after release.
REQ-030 With GMII2XGMII_ERR_EN defined, the bench SHALL pulse gmii_er at byte 10 and check lane 2 of the second word is 0xFE with txc=0x04.
